// File: rtl/regwr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regwr_arb_pkg
// Description : Shared register-file defines and the pending-write entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package regwr_arb_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [RegBus-1:0]     ZeroWord    = '0;
  localparam logic                  WriteEnable = 1'b1;
  localparam logic [RegAddrBus-1:0] RegZeroAddr = '0;

  typedef struct packed {
    logic                  live;
    logic [RegAddrBus-1:0] waddr;
    logic [RegBus-1:0]     wdata;
  } pend_entry_t;

endpackage
`default_nettype wire

// File: rtl/regwr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : regwr_fifo
// Description : Pending load-write buffer with parallel address-match kill.
// Revision    : 1.0 - initial release
// ============================================================================
module regwr_fifo
  import regwr_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  pend_entry_t                  push_entry,
  input  logic                         pop,
  input  logic                         kill_en,
  input  logic [RegAddrBus-1:0]        kill_addr,
  output pend_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  pend_entry_t        r_mem [DEPTH];
  logic [PW-1:0]      r_wptr;
  logic [PW-1:0]      r_rptr;
  logic [CW-1:0]      r_cnt;
  pend_entry_t        w_push_entry;

  // A write-back to the same register in the push cycle makes the entry stale.
  always_comb begin
    w_push_entry      = push_entry;
    w_push_entry.live = push_entry.live & ~(kill_en & (push_entry.waddr == kill_addr));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (r_wptr == PW'(i))) begin
          r_mem[i] <= w_push_entry;
        end else if (kill_en && (r_mem[i].waddr == kill_addr)) begin
          r_mem[i].live <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (push) r_wptr <= (r_wptr == PW'(DEPTH-1)) ? '0 : r_wptr + PW'(1);
      if (pop)  r_rptr <= (r_rptr == PW'(DEPTH-1)) ? '0 : r_rptr + PW'(1);
      if (push && !pop)      r_cnt <= r_cnt + CW'(1);
      else if (pop && !push) r_cnt <= r_cnt - CW'(1);
    end
  end

  assign head  = r_mem[r_rptr];
  assign count = r_cnt;
  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/regwr_arb.sv
`default_nettype none
// ============================================================================
// Module      : regwr_arb
// Description : Register-file write-port arbiter, write-back over late loads.
// Revision    : 1.0 - initial release
// ============================================================================
module regwr_arb
  import regwr_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wb_we,
  input  logic [RegAddrBus-1:0]       wb_waddr,
  input  logic [RegBus-1:0]           wb_wdata,
  input  logic                        lsu_valid,
  output logic                        lsu_ready,
  input  logic [RegAddrBus-1:0]       lsu_waddr,
  input  logic [RegBus-1:0]           lsu_wdata,
  output logic                        rf_we,
  output logic [RegAddrBus-1:0]       rf_waddr,
  output logic [RegBus-1:0]           rf_wdata,
  output logic                        stall_req,
  output logic [$clog2(DEPTH+1)-1:0]  pend_cnt
);

  localparam int SW = $clog2(STARVE_MAX+1);

  logic          w_wb_eff;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  pend_entry_t   w_push_entry;
  pend_entry_t   w_head;
  logic [SW-1:0] r_starve;

  assign w_wb_eff     = ~rst & wb_we & (wb_waddr != RegZeroAddr);
  assign lsu_ready    = ~rst & ~w_full;
  // Loads to r0 are accepted but never buffered.
  assign w_push       = lsu_valid & lsu_ready & (lsu_waddr != RegZeroAddr);
  assign w_pop        = ~rst & ~w_wb_eff & ~w_empty;
  assign w_push_entry = {WriteEnable, lsu_waddr, lsu_wdata};

  regwr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .kill_en    (w_wb_eff),
    .kill_addr  (wb_waddr),
    .head       (w_head),
    .count      (pend_cnt),
    .full       (w_full),
    .empty      (w_empty)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = RegZeroAddr;
    rf_wdata = ZeroWord;
    if (w_wb_eff) begin
      rf_we    = WriteEnable;
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end else if (w_pop) begin
      rf_we    = w_head.live;
      rf_waddr = w_head.waddr;
      rf_wdata = w_head.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (r_starve != SW'(STARVE_MAX)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  assign stall_req = (r_starve == SW'(STARVE_MAX));

endmodule
`default_nettype wire

// File: tb/tb_regwr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regwr_arb
// Description : Directed self-checking bench for regwr_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regwr_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_waddr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [1:0]  pend_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf_model [32] = '{default: 32'h0};

  regwr_arb #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_waddr (lsu_waddr),
    .lsu_wdata (lsu_wdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .stall_req (stall_req),
    .pend_cnt  (pend_cnt)
  );

  always #5 clk = ~clk;

  // Register file as seen through the single write port.
  always @(posedge clk) if (rf_we) rf_model[rf_waddr] <= rf_wdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h55;
    step(); step(); #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0h exp=0", rf_we); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall_req); end
    checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL reset_pend got=%0d exp=0", pend_cnt); end
    checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0h exp=0", lsu_ready); end
    step();
    wb_we = 1'b0; rst = 1'b0; #1;
    checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%0h exp=1", lsu_ready); end
    step();
  endtask

  task automatic test_lsu_basic();
    lsu_valid = 1'b1; lsu_waddr = 5'd5; lsu_wdata = 32'hAAAA0001; #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL basic_no_passthru got=%0h exp=0", rf_we); end
    step();
    lsu_valid = 1'b0; #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hAAAA0001})
      begin failures++; $display("FAIL basic_write got=%0h/%0d/%0h exp=1/5/aaaa0001", rf_we, rf_waddr, rf_wdata); end
    checks++; if (pend_cnt !== 2'd1) begin failures++; $display("FAIL basic_pend1 got=%0d exp=1", pend_cnt); end
    step();
    checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL basic_pend0 got=%0d exp=0", pend_cnt); end
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'h0})
      begin failures++; $display("FAIL basic_idle got=%0h/%0d/%0h exp=0/0/0", rf_we, rf_waddr, rf_wdata); end
    checks++; if (rf_model[5] !== 32'hAAAA0001) begin failures++; $display("FAIL basic_r5 got=%0h exp=aaaa0001", rf_model[5]); end
  endtask

  task automatic test_same_cycle_kill();
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h11;
    lsu_valid = 1'b1; lsu_waddr = 5'd3; lsu_wdata = 32'h22; #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11})
      begin failures++; $display("FAIL kill_wb got=%0h/%0d/%0h exp=1/3/11", rf_we, rf_waddr, rf_wdata); end
    step();
    wb_we = 1'b0; lsu_valid = 1'b0; #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd3, 32'h22})
      begin failures++; $display("FAIL kill_pop got=%0h/%0d/%0h exp=0/3/22", rf_we, rf_waddr, rf_wdata); end
    checks++; if (pend_cnt !== 2'd1) begin failures++; $display("FAIL kill_slot got=%0d exp=1", pend_cnt); end
    step();
    checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL kill_drain got=%0d exp=0", pend_cnt); end
    checks++; if (rf_model[3] !== 32'h11) begin failures++; $display("FAIL kill_r3 got=%0h exp=11", rf_model[3]); end
  endtask

  task automatic test_starve();
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h70;
    lsu_valid = 1'b1; lsu_waddr = 5'd9; lsu_wdata = 32'h99; #1;
    checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd7}) begin failures++; $display("FAIL starve_wb got=%0h/%0d exp=1/7", rf_we, rf_waddr); end
    step();
    lsu_waddr = 5'd10; lsu_wdata = 32'hA0; #1;
    checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL starve_ready1 got=%0h exp=1", lsu_ready); end
    step();
    lsu_valid = 1'b0; wb_waddr = 5'd9; wb_wdata = 32'h90; #1;
    checks++; if (pend_cnt !== 2'd2) begin failures++; $display("FAIL starve_pend2 got=%0d exp=2", pend_cnt); end
    checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL starve_full_ready got=%0h exp=0", lsu_ready); end
    step();
    wb_waddr = 5'd7; wb_wdata = 32'h71;
    step(); #1;
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL starve_early got=%0h exp=0", stall_req); end
    step();
    lsu_valid = 1'b1; lsu_waddr = 5'd11; lsu_wdata = 32'hBB; #1;
    checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL starve_stall got=%0h exp=1", stall_req); end
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h71})
      begin failures++; $display("FAIL starve_wb_prio got=%0h/%0d/%0h exp=1/7/71", rf_we, rf_waddr, rf_wdata); end
    step();
    wb_we = 1'b0; lsu_valid = 1'b0; #1;
    checks++; if (pend_cnt !== 2'd2) begin failures++; $display("FAIL starve_no_accept got=%0d exp=2", pend_cnt); end
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd9, 32'h99})
      begin failures++; $display("FAIL starve_killed_pop got=%0h/%0d/%0h exp=0/9/99", rf_we, rf_waddr, rf_wdata); end
    step();
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL starve_release got=%0h exp=0", stall_req); end
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'hA0})
      begin failures++; $display("FAIL starve_pop2 got=%0h/%0d/%0h exp=1/10/a0", rf_we, rf_waddr, rf_wdata); end
    step();
    checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL starve_drain got=%0d exp=0", pend_cnt); end
    checks++; if (rf_model[9] !== 32'h90) begin failures++; $display("FAIL starve_r9 got=%0h exp=90", rf_model[9]); end
    checks++; if (rf_model[11] !== 32'h0) begin failures++; $display("FAIL starve_r11 got=%0h exp=0", rf_model[11]); end
  endtask

  task automatic test_r0();
    lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'hDEAD; #1;
    checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got=%0h exp=1", lsu_ready); end
    step();
    lsu_valid = 1'b0; #1;
    checks++; if ({pend_cnt, rf_we} !== {2'd0, 1'b0}) begin failures++; $display("FAIL r0_lsu got=%0d/%0h exp=0/0", pend_cnt, rf_we); end
    wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hBEEF; #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'h0})
      begin failures++; $display("FAIL r0_wb got=%0h/%0d/%0h exp=0/0/0", rf_we, rf_waddr, rf_wdata); end
    step();
    wb_we = 1'b0;
  endtask

  task automatic test_full_and_wrap();
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h77;
    lsu_valid = 1'b1; lsu_waddr = 5'd12; lsu_wdata = 32'hC12;
    step();
    lsu_waddr = 5'd13; lsu_wdata = 32'hC13;
    step();
    wb_we = 1'b0; lsu_waddr = 5'd14; lsu_wdata = 32'hC14; #1;
    checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL full_pop_ready got=%0h exp=0", lsu_ready); end
    checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd12}) begin failures++; $display("FAIL full_pop_head got=%0h/%0d exp=1/12", rf_we, rf_waddr); end
    step();
    lsu_valid = 1'b0; #1;
    checks++; if (pend_cnt !== 2'd1) begin failures++; $display("FAIL full_no_push got=%0d exp=1", pend_cnt); end
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd13, 32'hC13})
      begin failures++; $display("FAIL full_second got=%0h/%0d/%0h exp=1/13/c13", rf_we, rf_waddr, rf_wdata); end
    step();
    for (int i = 0; i < 6; i++) begin
      lsu_valid = 1'b1; lsu_waddr = 5'(16 + i); lsu_wdata = 32'hC000_0000 + i; #1;
      if (i > 0) begin
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(15 + i), 32'hC000_0000 + 32'(i - 1)})
          begin failures++; $display("FAIL wrap_order[%0d] got=%0h/%0d/%0h exp=1/%0d/%0h", i, rf_we, rf_waddr, rf_wdata, 15 + i, 32'hC000_0000 + 32'(i - 1)); end
        checks++; if (pend_cnt !== 2'd1) begin failures++; $display("FAIL wrap_pend[%0d] got=%0d exp=1", i, pend_cnt); end
      end
      step();
    end
    lsu_valid = 1'b0; #1;
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd21, 32'hC000_0005})
      begin failures++; $display("FAIL wrap_last got=%0h/%0d/%0h exp=1/21/c0000005", rf_we, rf_waddr, rf_wdata); end
    step();
    checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL wrap_drain got=%0d exp=0", pend_cnt); end
  endtask

  task automatic test_reset_mid();
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h7A;
    lsu_valid = 1'b1; lsu_waddr = 5'd24; lsu_wdata = 32'hE24;
    step();
    lsu_waddr = 5'd25; lsu_wdata = 32'hE25;
    step();
    lsu_valid = 1'b0; #2;
    rst = 1'b1; #1;
    checks++; if ({rf_we, pend_cnt, lsu_ready, stall_req} !== {1'b0, 2'd0, 1'b0, 1'b0})
      begin failures++; $display("FAIL midrst got=%0h/%0d/%0h/%0h exp=0/0/0/0", rf_we, pend_cnt, lsu_ready, stall_req); end
    step(); step();
    wb_we = 1'b0; rst = 1'b0; #1;
    checks++; if ({rf_we, lsu_ready} !== {1'b0, 1'b1}) begin failures++; $display("FAIL midrst_release got=%0h/%0h exp=0/1", rf_we, lsu_ready); end
    step(); step();
    checks++; if ({rf_we, pend_cnt} !== {1'b0, 2'd0}) begin failures++; $display("FAIL midrst_stale got=%0h/%0d exp=0/0", rf_we, pend_cnt); end
    checks++; if ({rf_model[24], rf_model[25]} !== 64'h0)
      begin failures++; $display("FAIL midrst_lost got=%0h/%0h exp=0/0", rf_model[24], rf_model[25]); end
  endtask

  initial begin
    test_reset();
    test_lsu_basic();
    test_same_cycle_kill();
    test_starve();
    test_r0();
    test_full_and_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regwr_arb.md
REGWR_ARB -- requirements
Module: regwr_arb

Interface
REQ-001 SHALL have parameters: DEPTH, default 2, number of pending-write buffer entries; STARVE_MAX, default 4, number of blocked cycles before stall_req asserts.
REQ-002 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-003 Ports, as name / direction / width / meaning:
- clk / in / 1 / clock.
- rst / in / 1 / asynchronous active-high reset.
- wb_we / in / 1 / pipeline write-back write request.
- wb_waddr / in / RegAddrBus (5) / pipeline destination register.
- wb_wdata / in / RegBus (32) / pipeline write data.
- lsu_valid / in / 1 / late load-return request.
- lsu_ready / out / 1 / this block accepts the load return this cycle.
- lsu_waddr / in / 5 / load-return destination register.
- lsu_wdata / in / 32 / load-return data.
- rf_we / out / 1 / register-file write enable.
- rf_waddr / out / 5 / register-file write address.
- rf_wdata / out / 32 / register-file write data.
- stall_req / out / 1 / request to freeze the pipeline write-back.
- pend_cnt / out / clog2(DEPTH+1) / occupied buffer entries.

Function
REQ-004 SHALL share the register file's single write port between the pipeline write-back (wb) and the load unit (lsu).
REQ-005 wb write SHALL be effective when wb_we=1 and wb_waddr!=0, and SHALL appear on rf_* combinationally in the same cycle (zero latency).
REQ-006 wb SHALL have fixed priority; an effective wb write SHALL never be dropped or delayed.
REQ-007 lsu_ready SHALL be 1 exactly when pend_cnt<DEPTH, registered-state only, with no same-cycle pass-through when full.
REQ-008 An lsu transfer occurs when lsu_valid=1 and lsu_ready=1; when lsu_waddr!=0 it SHALL push {live=1, waddr, wdata} at the FIFO tail on the next clk edge.
REQ-009 An lsu transfer with lsu_waddr=0 SHALL be accepted and discarded, with no push.
REQ-010 An lsu write SHALL reach rf_* no earlier than 1 cycle after its transfer.
REQ-011 When no effective wb write is present and the FIFO is non-empty, the head SHALL pop and drive rf_we equal to the head's live bit, with rf_waddr/rf_wdata taken from the head.
REQ-012 When there is neither a wb write nor a FIFO entry, rf_we SHALL be 0, and rf_waddr/rf_wdata SHALL be 0.
REQ-013 Ordering rule: a pending lsu entry is older than any wb write presented after or in the same cycle as its transfer.
REQ-014 An effective wb write SHALL clear the live bit of every FIFO entry with a matching waddr, including an entry being pushed in the same cycle.
REQ-015 Killed entries SHALL still occupy a slot and pop with rf_we=0.
REQ-016 Push and pop in the same cycle SHALL leave pend_cnt unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-017 Starve counter behaviour:
- SHALL increment each cycle the FIFO is non-empty and no pop occurs.
- SHALL clear on any pop or when the FIFO is empty.
- SHALL saturate at STARVE_MAX.
REQ-018 stall_req SHALL be 1 exactly when the starve counter equals STARVE_MAX, and SHALL drop the cycle after a pop.
REQ-019 While stall_req=1, the requirements of REQ-006 and REQ-014 SHALL still hold.

Reset
REQ-020 rst=1 SHALL asynchronously do all of the following:
- empty the FIFO and clear all live bits;
- zero the pointers and the starve counter;
- force rf_we=0, stall_req=0, pend_cnt=0 and lsu_ready=0 while rst is high.
REQ-021 Pending lsu entries present at reset SHALL be lost without any register-file write.
REQ-022 After rst deasserts, lsu_ready SHALL be 1 in the first cycle.

Structure
REQ-023 RegBus, RegAddrBus, ZeroWord, WriteEnable and the register-0 address SHALL come from the shared defines package; DEPTH and STARVE_MAX SHALL be local parameters of this block.
REQ-024 The buffer SHALL be one sub-module, regwr_fifo, holding entry storage, pointers, count and the parallel address-match kill port; arbitration and the starve counter SHALL remain in regwr_arb.

Verification
REQ-025 lsu push of (r5, 0xAAAA0001) with wb idle -> rf_we=1, r5, 0xAAAA0001 on the next cycle; pend_cnt goes 1 then 0.
REQ-026 Same-cycle wb (r3, 0x11) and lsu push of (r3, 0x22) -> rf writes 0x11 now; the r3 entry later pops with rf_we=0; the final value of r3 is 0x11.
REQ-027 Two lsu pushes with wb continuously writing r7 -> lsu_ready=0 once pend_cnt=2; stall_req=1 after 4 blocked cycles; releasing wb pops the head; stall_req=0 the following cycle.
REQ-028 lsu push to r0, and wb write to r0 -> lsu accepted; pend_cnt stays 0; rf_we=0 in both cases.
REQ-029 FIFO full plus a same-cycle pop and a new lsu_valid -> lsu not accepted (ready=0); pointer wrap verified over 6 push/pop pairs with data order preserved.
REQ-030 rst asserted mid-cycle with 2 pending entries -> rf_we=0 and pend_cnt=0 immediately; no stale write after release.
